react_match_fsm: RTL and testbench
==================================

Name: react_match_fsm

Overview:
- Parametrised successor to the two-player reaction-time test controller.
- Sequences NUM_PLAYERS players through 2^TRIALS_LOG2 trials each, in round-robin order.
- Accumulates per-player reaction times, computes each player's average, then scans for the winner over multiple cycles.
- Sits between the timer/LFSR delay unit (start/cleared/overflow pulses) and the display/LED drivers.

Parameters:
- NUM_PLAYERS, 2, number of players; 2..8.
- TRIALS_LOG2, 3, log2 of trials per player (3 gives 8 trials).
- TIME_W, 10, reaction-time width in ms.
- MAX_TIME, 999, saturation and penalty value in ms.

Ports:
- clk  in  1  system clock (12 MHz).
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- action_i  in  1  player button pulse; starts a player's round or acknowledges the result.
- start_i  in  1  random delay elapsed; the stimulus goes on.
- cleared_i  in  1  external counter cleared.
- react_i  in  1  player reacted.
- overflow_i  in  1  reaction counter reached its limit.
- react_time_i  in  TIME_W  measured time, valid while react_i is high.
- state_o  out  4  current state.
- cur_player_o  out  3  active player index.
- trial_cnt_o  out  NUM_PLAYERS*(TRIALS_LOG2+1)  packed per-player trial counts; player 0 in the LSBs.
- avg_o  out  NUM_PLAYERS*TIME_W  packed per-player averages.
- winner_o  out  3  index of the lowest average.
- tie_o  out  1  another player equals the winning average.
- done_o  out  1  result valid.

Behaviour:
- Reset (also mid-operation):
  - state IDLE; cur_player 0.
  - All sums, trial counts, averages, winner_o and tie_o are 0; done_o is 0.
  - Takes effect on the next clk edge.
- States: IDLE=0, WAIT=1, CLR_CNT1=2, START=3, STORAGE=4, CLR_CNT2=5, AVERAGE=6, COMPARE=7, DONE=8. Inputs outside the listed conditions are ignored.
- IDLE: action_i -> WAIT.
- WAIT: start_i -> CLR_CNT1.
- CLR_CNT1: cleared_i -> START.
- START:
  - react_i latches sample = min(react_time_i, MAX_TIME), then -> STORAGE.
  - overflow_i alone latches sample = MAX_TIME, then -> STORAGE.
  - If react_i and overflow_i are high in the same cycle, react_i wins.
- STORAGE (1 cycle):
  - sum[p] += sample; trial[p] += 1.
  - If the new trial[p] equals 2^TRIALS_LOG2 -> AVERAGE, else -> CLR_CNT2.
- CLR_CNT2: cleared_i -> WAIT.
- AVERAGE (1 cycle):
  - avg[p] = sum[p] >> TRIALS_LOG2 (truncating).
  - If every player's trial count equals 2^TRIALS_LOG2 -> COMPARE with scan index 0.
  - Otherwise cur_player advances to the next player whose count is below 2^TRIALS_LOG2 (wrapping) -> IDLE.
- COMPARE (NUM_PLAYERS cycles): checks one player per cycle.
  - Cycle 0 loads best = avg[0], winner 0, tie 0.
  - Each later player: avg < best replaces best and winner and clears tie; avg == best sets tie.
  - After the last player -> DONE.
  - The lowest index wins on equality.
- DONE: done_o=1 and results are held. action_i clears sums, counts, averages and done_o, sets cur_player 0 -> IDLE.
- Widths:
  - Sum is TIME_W+TRIALS_LOG2 bits and cannot overflow given saturation.
  - Trial count is TRIALS_LOG2+1 bits and never exceeds 2^TRIALS_LOG2.
- Outputs are registered. state_o reflects the state one cycle after the transition condition.

Optional Feature:
- Macro: REACT_FALSE_START_EN.
- Defined: react_i in WAIT is a false start. The sample is MAX_TIME, it is stored as a normal trial (-> STORAGE), and the delay unit is re-armed via the normal CLR_CNT2 path.
- Undefined: react_i in WAIT is ignored and the trial continues.

Test Plan:
- Defaults: two players, 8 trials each, all react_time_i=200 -> avg 200/200, winner 0, tie 1, done_o=1, and state DONE after the last COMPARE cycle.
- Player 0 times 100..800 step 100, player 1 all 300 -> avg0=450, avg1=300, winner 1, tie 0.
- react_time_i=1023 on a trial -> that sample is stored as 999; 8x1023 -> avg 999.
- overflow_i without react in START -> sample 999 and trial count increments. react_i and overflow_i together with time 150 -> sample 150.
- NUM_PLAYERS=3, TRIALS_LOG2=1: player order is 0, 1, 2. Averages 500/200/200 -> winner 1, tie 1. Assert rst in the middle of player 1 -> all outputs 0, state IDLE, cur_player 0.
- With REACT_FALSE_START_EN: react_i in WAIT -> STORAGE, sample 999. Without it -> state stays WAIT and the count is unchanged.

Source files
------------

// File: rtl/react_match_if.sv
// Handshake and result bus between react_match_fsm, the timer/LFSR delay unit
// and the display/LED drivers.
// master: the side that drives the pulses (delay unit, buttons).
// slave:  the controller itself.
interface react_match_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int TRIALS_LOG2 = 3,
  parameter int TIME_W      = 10
);
  logic                                   action_i;
  logic                                   start_i;
  logic                                   cleared_i;
  logic                                   react_i;
  logic                                   overflow_i;
  logic [TIME_W-1:0]                      react_time_i;
  logic [3:0]                             state_o;
  logic [2:0]                             cur_player_o;
  logic [NUM_PLAYERS*(TRIALS_LOG2+1)-1:0] trial_cnt_o;
  logic [NUM_PLAYERS*TIME_W-1:0]          avg_o;
  logic [2:0]                             winner_o;
  logic                                   tie_o;
  logic                                   done_o;

  modport master (
    output action_i, start_i, cleared_i, react_i, overflow_i, react_time_i,
    input  state_o, cur_player_o, trial_cnt_o, avg_o, winner_o, tie_o, done_o
  );

  modport slave (
    input  action_i, start_i, cleared_i, react_i, overflow_i, react_time_i,
    output state_o, cur_player_o, trial_cnt_o, avg_o, winner_o, tie_o, done_o
  );
endinterface

// File: rtl/react_match_fsm.sv
// Multi-player reaction-time match controller.
// Runs each player through 2^TRIALS_LOG2 trials, accumulates saturated
// reaction times, averages them, then scans one player per cycle for the
// lowest average.
// Optional build macro REACT_FALSE_START_EN: a react pulse while waiting for
// the stimulus counts as a false start and stores a MAX_TIME penalty trial.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for the current player to press action
// WAIT     | random delay running, waiting for start_i
// CLR_CNT1 | reaction counter being cleared before the stimulus
// START    | stimulus on, waiting for react_i or overflow_i
// STORAGE  | add latched sample to the current player's sum/count
// CLR_CNT2 | counter cleared between trials of the same player
// AVERAGE  | compute current player's average, pick next player
// COMPARE  | scan averages, one player per cycle
// DONE     | results valid and held until action_i
module react_match_fsm #(
  parameter int NUM_PLAYERS = 2,
  parameter int TRIALS_LOG2 = 3,
  parameter int TIME_W      = 10,
  parameter int MAX_TIME    = 999
) (
  input logic         clk,
  input logic         rst,
  react_match_if.slave bus
);

  localparam int SUM_W = TIME_W + TRIALS_LOG2;
  localparam int CNT_W = TRIALS_LOG2 + 1;
  localparam logic [CNT_W-1:0]  TRIALS = CNT_W'(1 << TRIALS_LOG2);
  localparam logic [TIME_W-1:0] MAX_T  = TIME_W'(MAX_TIME);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WAIT     = 4'd1,
    CLR_CNT1 = 4'd2,
    START    = 4'd3,
    STORAGE  = 4'd4,
    CLR_CNT2 = 4'd5,
    AVERAGE  = 4'd6,
    COMPARE  = 4'd7,
    DONE     = 4'd8
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cur_q, cur_d;
  logic [2:0]        scan_q, scan_d;
  logic [2:0]        winner_q, winner_d;
  logic              tie_q, tie_d;
  logic              done_q, done_d;
  logic [TIME_W-1:0] sample_q, sample_d;
  logic [TIME_W-1:0] best_q, best_d;
  logic [SUM_W-1:0]  sum_q   [NUM_PLAYERS];
  logic [SUM_W-1:0]  sum_d   [NUM_PLAYERS];
  logic [CNT_W-1:0]  trial_q [NUM_PLAYERS];
  logic [CNT_W-1:0]  trial_d [NUM_PLAYERS];
  logic [TIME_W-1:0] avg_q   [NUM_PLAYERS];
  logic [TIME_W-1:0] avg_d   [NUM_PLAYERS];

  logic [TIME_W-1:0] sat_time;
  logic [CNT_W-1:0]  cur_new_cnt;
  logic [TIME_W-1:0] scan_avg;
  logic              all_full;
  logic              found;

  // Next-state, datapath updates and scan, all defaulting to hold.
  always_comb begin
    int idx;
    state_d     = state_q;
    cur_d       = cur_q;
    scan_d      = scan_q;
    winner_d    = winner_q;
    tie_d       = tie_q;
    done_d      = done_q;
    sample_d    = sample_q;
    best_d      = best_q;
    sum_d       = sum_q;
    trial_d     = trial_q;
    avg_d       = avg_q;
    idx         = 0;
    found       = 1'b0;
    all_full    = 1'b1;
    cur_new_cnt = '0;
    scan_avg    = '0;
    sat_time    = (bus.react_time_i > MAX_T) ? MAX_T : bus.react_time_i;

    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (cur_q == 3'(p)) cur_new_cnt = trial_q[p] + CNT_W'(1);
      if (scan_q == 3'(p)) scan_avg = avg_q[p];
      if (trial_q[p] != TRIALS) all_full = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.action_i) state_d = WAIT;
      end
      WAIT: begin
`ifdef REACT_FALSE_START_EN
        // A press before the stimulus is penalised, then re-armed via CLR_CNT2.
        if (bus.react_i) begin
          sample_d = MAX_T;
          state_d  = STORAGE;
        end else if (bus.start_i) begin
          state_d = CLR_CNT1;
        end
`else
        if (bus.start_i) state_d = CLR_CNT1;
`endif
      end
      CLR_CNT1: begin
        if (bus.cleared_i) state_d = START;
      end
      START: begin
        if (bus.react_i) begin
          sample_d = sat_time;
          state_d  = STORAGE;
        end else if (bus.overflow_i) begin
          sample_d = MAX_T;
          state_d  = STORAGE;
        end
      end
      STORAGE: begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          if (cur_q == 3'(p)) begin
            sum_d[p]   = sum_q[p] + SUM_W'(sample_q);
            trial_d[p] = cur_new_cnt;
          end
        end
        state_d = (cur_new_cnt == TRIALS) ? AVERAGE : CLR_CNT2;
      end
      CLR_CNT2: begin
        if (bus.cleared_i) state_d = WAIT;
      end
      AVERAGE: begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          if (cur_q == 3'(p)) avg_d[p] = sum_q[p][SUM_W-1:TRIALS_LOG2];
        end
        if (all_full) begin
          scan_d  = '0;
          state_d = COMPARE;
        end else begin
          // First unfinished player after the current one, wrapping.
          for (int k = 1; k < NUM_PLAYERS; k++) begin
            idx = int'(cur_q) + k;
            if (idx >= NUM_PLAYERS) idx = idx - NUM_PLAYERS;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
              if (!found && p == idx && trial_q[p] != TRIALS) begin
                found = 1'b1;
                cur_d = 3'(p);
              end
            end
          end
          state_d = IDLE;
        end
      end
      COMPARE: begin
        if (scan_q == 3'd0) begin
          best_d   = scan_avg;
          winner_d = 3'd0;
          tie_d    = 1'b0;
        end else if (scan_avg < best_q) begin
          best_d   = scan_avg;
          winner_d = scan_q;
          tie_d    = 1'b0;
        end else if (scan_avg == best_q) begin
          tie_d = 1'b1;
        end
        if (scan_q == 3'(NUM_PLAYERS - 1)) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          scan_d = scan_q + 3'd1;
        end
      end
      DONE: begin
        if (bus.action_i) begin
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            sum_d[p]   = '0;
            trial_d[p] = '0;
            avg_d[p]   = '0;
          end
          done_d  = 1'b0;
          cur_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      scan_q   <= '0;
      winner_q <= '0;
      tie_q    <= 1'b0;
      done_q   <= 1'b0;
      sample_q <= '0;
      best_q   <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        sum_q[p]   <= '0;
        trial_q[p] <= '0;
        avg_q[p]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      scan_q   <= scan_d;
      winner_q <= winner_d;
      tie_q    <= tie_d;
      done_q   <= done_d;
      sample_q <= sample_d;
      best_q   <= best_d;
      sum_q    <= sum_d;
      trial_q  <= trial_d;
      avg_q    <= avg_d;
    end
  end

  assign bus.state_o      = state_q;
  assign bus.cur_player_o = cur_q;
  assign bus.winner_o     = winner_q;
  assign bus.tie_o        = tie_q;
  assign bus.done_o       = done_q;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
    assign bus.trial_cnt_o[g*CNT_W +: CNT_W] = trial_q[g];
    assign bus.avg_o[g*TIME_W +: TIME_W]     = avg_q[g];
  end

endmodule

// File: tb/tb_react_match_fsm.sv
// Bench for react_match_fsm: a 2-player/8-trial instance driven from a
// vector table (fixed and random rows) and a 3-player/2-trial instance for
// player ordering and mid-match reset.
module tb_react_match_fsm;

  localparam int S_IDLE = 0, S_WAIT = 1, S_CLR1 = 2, S_START = 3, S_STOR = 4,
                 S_CLR2 = 5, S_AVG = 6, S_CMP = 7, S_DONE = 8;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_c = 1'b1;
  int   vec = 0;
  int   miss = 0;

  always #5 clk = ~clk;

  react_match_if #(.NUM_PLAYERS(2), .TRIALS_LOG2(3), .TIME_W(10)) ifa ();
  react_match_if #(.NUM_PLAYERS(3), .TRIALS_LOG2(1), .TIME_W(10)) ifb ();

  react_match_fsm #(.NUM_PLAYERS(2), .TRIALS_LOG2(3), .TIME_W(10), .MAX_TIME(999))
    dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  react_match_fsm #(.NUM_PLAYERS(3), .TRIALS_LOG2(1), .TIME_W(10), .MAX_TIME(999))
    dut_c (.clk(clk), .rst(rst_c), .bus(ifb));

  // mode: 0 react only, 1 overflow only, 2 react and overflow together
  typedef struct packed {
    logic [1:0][7:0][9:0] t;
    logic [1:0][7:0][1:0] m;
    logic [9:0]           ea0;
    logic [9:0]           ea1;
    logic [2:0]           ew;
    logic                 et;
  } row_t;

  row_t rows[10];

  task automatic chk(input string nm, input int act, input int exp);
    vec++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int get_st(input int sel);
    return (sel == 0) ? int'(ifa.state_o) : int'(ifb.state_o);
  endfunction
  function automatic int get_cur(input int sel);
    return (sel == 0) ? int'(ifa.cur_player_o) : int'(ifb.cur_player_o);
  endfunction
  function automatic int get_tc(input int sel, input int p);
    return (sel == 0) ? int'(ifa.trial_cnt_o[p*4 +: 4]) : int'(ifb.trial_cnt_o[p*2 +: 2]);
  endfunction
  function automatic int get_avg(input int sel, input int p);
    return (sel == 0) ? int'(ifa.avg_o[p*10 +: 10]) : int'(ifb.avg_o[p*10 +: 10]);
  endfunction

  task automatic step(input int sel, input bit act, input bit st, input bit clr,
                      input bit rea, input bit ovf, input int t);
    if (sel == 0) begin
      ifa.action_i = act; ifa.start_i = st; ifa.cleared_i = clr;
      ifa.react_i = rea; ifa.overflow_i = ovf; ifa.react_time_i = 10'(t);
    end else begin
      ifb.action_i = act; ifb.start_i = st; ifb.cleared_i = clr;
      ifb.react_i = rea; ifb.overflow_i = ovf; ifb.react_time_i = 10'(t);
    end
    @(posedge clk);
    #1;
    ifa.action_i = 0; ifa.start_i = 0; ifa.cleared_i = 0;
    ifa.react_i = 0; ifa.overflow_i = 0; ifa.react_time_i = '0;
    ifb.action_i = 0; ifb.start_i = 0; ifb.cleared_i = 0;
    ifb.react_i = 0; ifb.overflow_i = 0; ifb.react_time_i = '0;
  endtask

  // Trials i0..ntr-1 of player p, starting in WAIT.
  task automatic run_trials(input int sel, input int p, input int ntr, input int i0,
                            input logic [7:0][9:0] tv, input logic [7:0][1:0] mv,
                            input bit last, input int next_cur);
    for (int i = i0; i < ntr; i++) begin
      step(sel, 0, 1, 0, 0, 0, 0);
      chk("st_clr1", get_st(sel), S_CLR1);
      step(sel, 0, 0, 1, 0, 0, 0);
      chk("st_start", get_st(sel), S_START);
      step(sel, 0, 0, 0, mv[i] != 2'd1, mv[i] != 2'd0, int'(tv[i]));
      chk("st_storage", get_st(sel), S_STOR);
      step(sel, 0, 0, 0, 0, 0, 0);
      chk("trial_cnt", get_tc(sel, p), i + 1);
      if (i < ntr - 1) begin
        chk("st_clr2", get_st(sel), S_CLR2);
        step(sel, 0, 0, 1, 0, 0, 0);
        chk("st_wait", get_st(sel), S_WAIT);
      end else begin
        chk("st_average", get_st(sel), S_AVG);
        step(sel, 0, 0, 0, 0, 0, 0);
        if (last) chk("st_compare", get_st(sel), S_CMP);
        else begin
          chk("st_idle_next", get_st(sel), S_IDLE);
          chk("cur_next", get_cur(sel), next_cur);
        end
      end
    end
  endtask

  task automatic run_player(input int sel, input int p, input int ntr,
                            input logic [7:0][9:0] tv, input logic [7:0][1:0] mv,
                            input bit last, input int next_cur);
    chk("cur_at_start", get_cur(sel), p);
    step(sel, 1, 0, 0, 0, 0, 0);
    chk("st_wait0", get_st(sel), S_WAIT);
    run_trials(sel, p, ntr, 0, tv, mv, last, next_cur);
  endtask

  function automatic int samp(input int t, input int m);
    if (m == 1) return 999;
    return (t > 999) ? 999 : t;
  endfunction

  // Reference: average of saturated samples, lowest average wins, lowest
  // index on equal averages, tie when more than one player holds the minimum.
  function automatic row_t model(input row_t r);
    row_t o;
    int a[2];
    int mn, cnt;
    o = r;
    for (int p = 0; p < 2; p++) begin
      a[p] = 0;
      for (int i = 0; i < 8; i++) a[p] += samp(int'(r.t[p][i]), int'(r.m[p][i]));
      a[p] = a[p] / 8;
    end
    mn = (a[1] < a[0]) ? a[1] : a[0];
    cnt = 0;
    o.ew = 3'd0;
    for (int p = 1; p >= 0; p--) if (a[p] == mn) begin cnt++; o.ew = 3'(p); end
    o.et  = (cnt > 1);
    o.ea0 = 10'(a[0]);
    o.ea1 = 10'(a[1]);
    return o;
  endfunction

  initial begin
    logic [7:0][9:0] tz;
    logic [7:0][1:0] mz;
    logic [7:0][9:0] t3;
    ifa.action_i = 0; ifa.start_i = 0; ifa.cleared_i = 0;
    ifa.react_i = 0; ifa.overflow_i = 0; ifa.react_time_i = '0;
    ifb.action_i = 0; ifb.start_i = 0; ifb.cleared_i = 0;
    ifb.react_i = 0; ifb.overflow_i = 0; ifb.react_time_i = '0;
    tz = '0;
    mz = '0;

    // Vector table: fixed rows from hand-computed results, then random rows.
    for (int r = 0; r < 10; r++) rows[r] = '0;
    for (int i = 0; i < 8; i++) begin
      rows[0].t[0][i] = 10'd200;      rows[0].t[1][i] = 10'd200;
      rows[1].t[0][i] = 10'(100 * (i + 1)); rows[1].t[1][i] = 10'd300;
      rows[2].t[0][i] = 10'd1023;     rows[2].t[1][i] = 10'd500;
      rows[3].t[0][i] = 10'd100;      rows[3].t[1][i] = 10'd212;
      rows[4].t[0][i] = 10'd150;      rows[4].m[0][i] = 2'd2;
      rows[4].t[1][i] = 10'd5;        rows[4].m[1][i] = 2'd1;
    end
    rows[3].t[0][0] = 10'd1023;
    rows[0].ea0 = 200; rows[0].ea1 = 200; rows[0].ew = 0; rows[0].et = 1;
    rows[1].ea0 = 450; rows[1].ea1 = 300; rows[1].ew = 1; rows[1].et = 0;
    rows[2].ea0 = 999; rows[2].ea1 = 500; rows[2].ew = 1; rows[2].et = 0;
    rows[3].ea0 = 212; rows[3].ea1 = 212; rows[3].ew = 0; rows[3].et = 1;
    rows[4].ea0 = 150; rows[4].ea1 = 999; rows[4].ew = 0; rows[4].et = 0;
    for (int r = 5; r < 10; r++) begin
      for (int p = 0; p < 2; p++)
        for (int i = 0; i < 8; i++) begin
          int sel_m;
          rows[r].t[p][i] = 10'($urandom_range(0, 1023));
          sel_m = int'($urandom_range(0, 9));
          rows[r].m[p][i] = (sel_m == 0) ? 2'd1 : (sel_m == 1) ? 2'd2 : 2'd0;
        end
      if (r == 9) begin
        rows[r].t[1] = rows[r].t[0];
        rows[r].m[1] = rows[r].m[0];
      end
      rows[r] = model(rows[r]);
    end

    repeat (3) @(posedge clk);
    #1;
    rst_a = 0;
    rst_c = 0;

    chk("rst_state", int'(ifa.state_o), S_IDLE);
    chk("rst_cur", int'(ifa.cur_player_o), 0);
    chk("rst_trials", int'(ifa.trial_cnt_o), 0);
    chk("rst_avg", int'(ifa.avg_o), 0);
    chk("rst_winner", int'(ifa.winner_o), 0);
    chk("rst_tie", int'(ifa.tie_o), 0);
    chk("rst_done", int'(ifa.done_o), 0);

    for (int r = 0; r < 10; r++) begin
      run_player(0, 0, 8, rows[r].t[0], rows[r].m[0], 0, 1);
      run_player(0, 1, 8, rows[r].t[1], rows[r].m[1], 1, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("cmp_still", get_st(0), S_CMP);
      chk("done_low_in_cmp", int'(ifa.done_o), 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("st_done", get_st(0), S_DONE);
      chk("done_o", int'(ifa.done_o), 1);
      chk("avg0", get_avg(0, 0), int'(rows[r].ea0));
      chk("avg1", get_avg(0, 1), int'(rows[r].ea1));
      chk("winner", int'(ifa.winner_o), int'(rows[r].ew));
      chk("tie", int'(ifa.tie_o), int'(rows[r].et));
      step(0, 0, 0, 0, 0, 0, 0);
      chk("done_hold", get_st(0), S_DONE);
      chk("winner_hold", int'(ifa.winner_o), int'(rows[r].ew));
      step(0, 1, 0, 0, 0, 0, 0);
      chk("ack_idle", get_st(0), S_IDLE);
      chk("ack_done", int'(ifa.done_o), 0);
      chk("ack_trials", int'(ifa.trial_cnt_o), 0);
      chk("ack_avg", int'(ifa.avg_o), 0);
      chk("ack_cur", get_cur(0), 0);
    end

    // Press before the stimulus.
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 50);
`ifdef REACT_FALSE_START_EN
    chk("fs_storage", get_st(0), S_STOR);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("fs_clr2", get_st(0), S_CLR2);
    chk("fs_count", get_tc(0, 0), 1);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("fs_wait", get_st(0), S_WAIT);
    run_trials(0, 0, 8, 1, tz, mz, 0, 1);
    chk("fs_avg", get_avg(0, 0), 999 / 8);
`else
    chk("fs_ignored", get_st(0), S_WAIT);
    chk("fs_count", get_tc(0, 0), 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("ovf_in_wait_ignored", get_st(0), S_WAIT);
`endif
    rst_a = 1;
    step(0, 0, 0, 0, 0, 0, 0);
    rst_a = 0;
    chk("fs_rst_state", get_st(0), S_IDLE);
    chk("fs_rst_trials", int'(ifa.trial_cnt_o), 0);

    // Three-player build: reset in the middle of player 1.
    t3 = '0;
    t3[0] = 10'd500; t3[1] = 10'd500;
    run_player(1, 0, 2, t3, mz, 0, 1);
    chk("c_avg0_pre", get_avg(1, 0), 500);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    chk("c_mid_start", get_st(1), S_START);
    rst_c = 1;
    step(1, 0, 0, 0, 0, 0, 0);
    rst_c = 0;
    chk("c_rst_state", get_st(1), S_IDLE);
    chk("c_rst_cur", get_cur(1), 0);
    chk("c_rst_trials", int'(ifb.trial_cnt_o), 0);
    chk("c_rst_avg", int'(ifb.avg_o), 0);
    chk("c_rst_winner", int'(ifb.winner_o), 0);
    chk("c_rst_tie", int'(ifb.tie_o), 0);
    chk("c_rst_done", int'(ifb.done_o), 0);

    run_player(1, 0, 2, t3, mz, 0, 1);
    t3[0] = 10'd200; t3[1] = 10'd200;
    run_player(1, 1, 2, t3, mz, 0, 2);
    t3[0] = 10'd100; t3[1] = 10'd300;
    run_player(1, 2, 2, t3, mz, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("c_cmp_still", get_st(1), S_CMP);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("c_done", get_st(1), S_DONE);
    chk("c_done_o", int'(ifb.done_o), 1);
    chk("c_avg0", get_avg(1, 0), 500);
    chk("c_avg1", get_avg(1, 1), 200);
    chk("c_avg2", get_avg(1, 2), 200);
    chk("c_winner", int'(ifb.winner_o), 1);
    chk("c_tie", int'(ifb.tie_o), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
